ps_seq_stck: RTL and testbench

- Next-generation program-sequencer fetch core. Holds the fetch / decode / PC address pipeline and a parametrised-depth PC stack.
- Adds jump, call and return redirection, wrong-path kill bits, stall, and full/overflow/underflow sticky status.
- Sits between the instruction decoder and program memory. Supplies the PM address and serves PS universal-register reads and writes.

---
 rtl/ps_seq_stck_pkg.sv | 22 ++
 rtl/ps_seq_stck_if.sv | 37 +++
 rtl/ps_lifo_stck.sv | 72 +++++++
 rtl/ps_seq_stck.sv | 120 ++++++++++++
 tb/tb_ps_seq_stck.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/ps_seq_stck_pkg.sv
// Shared constants for the program-sequencer fetch core: ureg addresses
// and sticky status bit positions.
package ps_pkg;

  localparam logic [4:0] PS_FADDR  = 5'b00000;
  localparam logic [4:0] PS_DADDR  = 5'b00001;
  localparam logic [4:0] PS_PC     = 5'b00011;
  localparam logic [4:0] PS_PCSTK  = 5'b00100;
  localparam logic [4:0] PS_PCSTKP = 5'b00101;
  localparam logic [4:0] PS_STKY   = 5'b11110;

  localparam int STK_EMPTY = 0;
  localparam int STK_FULL  = 1;
  localparam int STK_OVF   = 2;
  localparam int STK_UNF   = 3;

  // Only the stack top and the sticky register accept ureg writes.
  function automatic logic ureg_writable(input logic [4:0] add);
    return (add == PS_PCSTK) || (add == PS_STKY);
  endfunction

endpackage

// File: rtl/ps_seq_stck_if.sv
// Decoder/bus-connect side of the program sequencer: control requests,
// ureg access and the pipeline addresses it reports back.
interface ps_seq_stck_if #(
  parameter int AW = 16
);
  logic          ps_stall;
  logic          ps_jmp;
  logic          ps_call;
  logic          ps_rts;
  logic [AW-1:0] ps_jmp_add;
  logic          ps_psh;
  logic          ps_pop;
  logic          ps_wrt_en;
  logic [4:0]    ps_wrt_add;
  logic [4:0]    ps_rd_add;
  logic [AW-1:0] bc_dt;
  logic [AW-1:0] ps_pm_add;
  logic [AW-1:0] ps_daddr;
  logic [AW-1:0] ps_pc;
  logic          ps_dvld;
  logic          ps_pcvld;
  logic [AW-1:0] ps_rd_dt;
  logic [3:0]    ps_stcky;

  modport master (
    output ps_stall, ps_jmp, ps_call, ps_rts, ps_jmp_add, ps_psh, ps_pop,
           ps_wrt_en, ps_wrt_add, ps_rd_add, bc_dt,
    input  ps_pm_add, ps_daddr, ps_pc, ps_dvld, ps_pcvld, ps_rd_dt, ps_stcky
  );

  modport slave (
    input  ps_stall, ps_jmp, ps_call, ps_rts, ps_jmp_add, ps_psh, ps_pop,
           ps_wrt_en, ps_wrt_add, ps_rd_add, bc_dt,
    output ps_pm_add, ps_daddr, ps_pc, ps_dvld, ps_pcvld, ps_rd_dt, ps_stcky
  );

endinterface

// File: rtl/ps_lifo_stck.sv
// PC stack: DEPTH x AW LIFO with count, full/empty flags and sticky
// overflow/underflow. Caller guarantees push and pop are never both high.
module ps_lifo_stck
  import ps_pkg::*;
#(
  parameter int AW    = 16,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] wdata,
  input  logic          top_wr,
  input  logic          stky_wr,
  input  logic [1:0]    stky_wdata,
  output logic [AW-1:0] top,
  output logic [CW-1:0] count,
  output logic [3:0]    stcky
);

  localparam int AI = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] mem [DEPTH];
  logic          full;
  logic          empty;
  logic          ovf;
  logic          unf;
  logic          ovf_set;
  logic          unf_set;
  logic [AI-1:0] top_idx;
  logic [AI-1:0] wr_idx;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign ovf_set = push && full;
  assign unf_set = pop && empty;
  assign top_idx = AI'(count - 1'b1);
  // Top write on an empty stack lands in entry 0 but stays invisible.
  assign wr_idx  = empty ? '0 : top_idx;

  assign top   = empty ? '0 : mem[top_idx];
  assign stcky = {unf, ovf, full, empty};

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[AI'(count)] <= wdata;
    end else if (top_wr && !push && !pop) begin
      mem[wr_idx] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      if (push && !full) begin
        count <= count + 1'b1;
      end else if (pop && !empty) begin
        count <= count - 1'b1;
      end
      // Hardware set wins over a software load in the same cycle.
      ovf <= ovf_set || (stky_wr ? stky_wdata[0] : ovf);
      unf <= unf_set || (stky_wr ? stky_wdata[1] : unf);
    end
  end

endmodule

// File: rtl/ps_seq_stck.sv
// Program-sequencer fetch core: fetch/decode/PC address pipeline with
// jump/call/return redirection, PC stack and ureg read/write port.
module ps_seq_stck
  import ps_pkg::*;
#(
  parameter int AW    = 16,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic         clk,
  input  logic         rst,
  ps_seq_stck_if.slave bus
);

  logic [AW-1:0] faddr;
  logic [AW-1:0] daddr;
  logic [AW-1:0] pc;
  logic          dvld;
  logic          pcvld;

  logic          rts_go;
  logic          call_go;
  logic          jmp_go;
  logic          pop_go;
  logic          psh_go;
  logic          stk_push;
  logic          stk_pop;
  logic          redirect;
  logic [AW-1:0] target;
  logic [AW-1:0] stk_wdata;
  logic          top_wr;
  logic          stky_wr;
  logic [AW-1:0] top;
  logic [CW-1:0] count;
  logic [3:0]    stcky;

  // Requests are ignored while stalled; the requester holds them.
  assign rts_go  = bus.ps_rts  && !bus.ps_stall;
  assign call_go = bus.ps_call && !bus.ps_stall && !bus.ps_rts;
  assign jmp_go  = bus.ps_jmp  && !bus.ps_stall && !bus.ps_rts && !bus.ps_call;
  assign pop_go  = bus.ps_pop  && !bus.ps_stall && !bus.ps_rts && !bus.ps_call;
  assign psh_go  = bus.ps_psh  && !bus.ps_stall && !bus.ps_rts && !bus.ps_call
                   && !bus.ps_pop;

  assign stk_push = call_go || psh_go;
  assign stk_pop  = rts_go || pop_go;
  assign redirect = rts_go || call_go || jmp_go;
  assign target   = rts_go ? top : bus.ps_jmp_add;

  assign stk_wdata = stk_push ? (pc + 1'b1) : bus.bc_dt;
  assign top_wr    = bus.ps_wrt_en && (bus.ps_wrt_add == PS_PCSTK);
  assign stky_wr   = bus.ps_wrt_en && (bus.ps_wrt_add == PS_STKY);

  ps_lifo_stck #(
    .AW    (AW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_stck (
    .clk        (clk),
    .rst        (rst),
    .push       (stk_push),
    .pop        (stk_pop),
    .wdata      (stk_wdata),
    .top_wr     (top_wr),
    .stky_wr    (stky_wr),
    .stky_wdata (bus.bc_dt[STK_UNF:STK_OVF]),
    .top        (top),
    .count      (count),
    .stcky      (stcky)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      faddr <= '0;
      daddr <= '0;
      pc    <= '0;
      dvld  <= 1'b0;
      pcvld <= 1'b0;
    end else if (!bus.ps_stall) begin
      daddr <= faddr;
      pc    <= daddr;
      if (redirect) begin
        // Kill the two in-flight instructions behind the redirect.
        faddr <= target;
        dvld  <= 1'b0;
        pcvld <= 1'b0;
      end else begin
        faddr <= faddr + 1'b1;
        dvld  <= 1'b1;
        pcvld <= dvld;
      end
    end
  end

  always_comb begin
    bus.ps_rd_dt = '0;
    if (bus.ps_wrt_en && (bus.ps_wrt_add == bus.ps_rd_add) &&
        ureg_writable(bus.ps_rd_add)) begin
      bus.ps_rd_dt = bus.bc_dt;
    end else begin
      case (bus.ps_rd_add)
        PS_FADDR:  bus.ps_rd_dt = faddr;
        PS_DADDR:  bus.ps_rd_dt = daddr;
        PS_PC:     bus.ps_rd_dt = pc;
        PS_PCSTK:  bus.ps_rd_dt = top;
        PS_PCSTKP: bus.ps_rd_dt = {{(AW-CW){1'b0}}, count};
        PS_STKY:   bus.ps_rd_dt = {{(AW-4){1'b0}}, stcky};
        default:   bus.ps_rd_dt = '0;
      endcase
    end
  end

  assign bus.ps_pm_add = faddr;
  assign bus.ps_daddr  = daddr;
  assign bus.ps_pc     = pc;
  assign bus.ps_dvld   = dvld;
  assign bus.ps_pcvld  = pcvld;
  assign bus.ps_stcky  = stcky;

endmodule

// File: tb/tb_ps_seq_stck.sv
// Directed plus randomized bench for ps_seq_stck, checked against a
// behavioural model of the sequencer kept in plain variables and an array.
module tb_ps_seq_stck;

  localparam int AW    = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ps_seq_stck_if #(.AW(AW)) bus ();

  ps_seq_stck #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [AW-1:0] m_fa, m_da, m_pc;
  logic          m_dv, m_pv, m_ovf, m_unf;
  logic [AW-1:0] m_stk [DEPTH];
  int            m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fa = '0; m_da = '0; m_pc = '0;
    m_dv = 1'b0; m_pv = 1'b0;
    m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  function automatic logic [3:0] m_stcky();
    return {m_unf, m_ovf, (m_cnt == DEPTH), (m_cnt == 0)};
  endfunction

  function automatic logic [AW-1:0] m_top();
    return (m_cnt > 0) ? m_stk[m_cnt-1] : '0;
  endfunction

  function automatic logic [AW-1:0] model_read();
    logic [4:0] ra = bus.ps_rd_add;
    if (bus.ps_wrt_en && bus.ps_wrt_add == ra && (ra == 5'd4 || ra == 5'd30))
      return bus.bc_dt;
    case (ra)
      5'd0:  return m_fa;
      5'd1:  return m_da;
      5'd3:  return m_pc;
      5'd4:  return m_top();
      5'd5:  return AW'(m_cnt);
      5'd30: return AW'(m_stcky());
      default: return '0;
    endcase
  endfunction

  // Applies one clock edge of sequencer behaviour to the model.
  task automatic model_update();
    logic [AW-1:0] tgt = '0;
    bit redir = 0, op = 0, ovs = 0, uns = 0;
    if (!bus.ps_stall) begin
      if (bus.ps_rts) begin
        redir = 1; op = 1; tgt = m_top();
        if (m_cnt > 0) m_cnt--; else uns = 1;
      end else if (bus.ps_call) begin
        redir = 1; op = 1; tgt = bus.ps_jmp_add;
        if (m_cnt < DEPTH) begin m_stk[m_cnt] = m_pc + 1'b1; m_cnt++; end
        else ovs = 1;
      end else begin
        if (bus.ps_jmp) begin redir = 1; tgt = bus.ps_jmp_add; end
        if (bus.ps_pop) begin
          op = 1;
          if (m_cnt > 0) m_cnt--; else uns = 1;
        end else if (bus.ps_psh) begin
          op = 1;
          if (m_cnt < DEPTH) begin m_stk[m_cnt] = m_pc + 1'b1; m_cnt++; end
          else ovs = 1;
        end
      end
    end
    if (bus.ps_wrt_en && bus.ps_wrt_add == 5'd4 && !op)
      m_stk[(m_cnt > 0) ? m_cnt-1 : 0] = bus.bc_dt;
    if (bus.ps_wrt_en && bus.ps_wrt_add == 5'd30) begin
      m_ovf = bus.bc_dt[2];
      m_unf = bus.bc_dt[3];
    end
    m_ovf = m_ovf | ovs;
    m_unf = m_unf | uns;
    if (!bus.ps_stall) begin
      m_pc = m_da;
      m_da = m_fa;
      if (redir) begin
        m_fa = tgt; m_dv = 0; m_pv = 0;
      end else begin
        m_fa = m_fa + 1'b1; m_pv = m_dv; m_dv = 1;
      end
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".pm_add"}, bus.ps_pm_add, m_fa);
    chk({tag, ".daddr"},  bus.ps_daddr,  m_da);
    chk({tag, ".pc"},     bus.ps_pc,     m_pc);
    chk({tag, ".dvld"},   bus.ps_dvld,   m_dv);
    chk({tag, ".pcvld"},  bus.ps_pcvld,  m_pv);
    chk({tag, ".stcky"},  bus.ps_stcky,  m_stcky());
  endtask

  task automatic tick(input string tag);
    #1;
    chk({tag, ".rd_dt"}, bus.ps_rd_dt, model_read());
    @(posedge clk);
    model_update();
    #1;
    chk_state(tag);
  endtask

  task automatic idle();
    bus.ps_stall = 0; bus.ps_jmp = 0; bus.ps_call = 0; bus.ps_rts = 0;
    bus.ps_jmp_add = '0; bus.ps_psh = 0; bus.ps_pop = 0;
    bus.ps_wrt_en = 0; bus.ps_wrt_add = '0; bus.ps_rd_add = '0; bus.bc_dt = '0;
  endtask

  initial begin
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.pm_add", bus.ps_pm_add, 16'h0);
    chk("rst.stcky", bus.ps_stcky, 4'b0001);
    chk("rst.dvld", bus.ps_dvld, 1'b0);
    rst = 1'b1;

    for (int i = 1; i <= 5; i++) begin
      tick("run");
      chk("run.pm_seq", bus.ps_pm_add, 16'(i));
    end
    chk("run.pcvld", bus.ps_pcvld, 1'b1);

    // Line up ps_pc = 0x0010, then call 0x0100.
    bus.ps_jmp = 1; bus.ps_jmp_add = 16'h0010; tick("jmp");
    idle(); tick("jmp1"); tick("jmp2");
    chk("jmp.pc", bus.ps_pc, 16'h0010);
    bus.ps_call = 1; bus.ps_jmp_add = 16'h0100; tick("call");
    chk("call.pm_add", bus.ps_pm_add, 16'h0100);
    chk("call.dvld", bus.ps_dvld, 1'b0);
    idle(); bus.ps_rd_add = 5'd4; tick("call1");
    chk("call.pcvld", bus.ps_pcvld, 1'b0);
    chk("call.top", bus.ps_rd_dt, 16'h0011);
    bus.ps_rd_add = 5'd5; #1;
    chk("call.count", bus.ps_rd_dt, 16'd1);

    // Empty the stack, then overfill it.
    idle(); bus.ps_pop = 1; tick("pop0");
    for (int i = 0; i < 5; i++) begin
      idle(); bus.ps_psh = 1; bus.ps_rd_add = 5'd4; tick("psh");
    end
    chk("ovf.stcky", bus.ps_stcky, 4'b0110);
    idle(); bus.ps_wrt_en = 1; bus.ps_wrt_add = 5'd30; bus.bc_dt = '0; tick("clr_ovf");
    chk("clr.stcky", bus.ps_stcky, 4'b0010);

    repeat (4) begin idle(); bus.ps_pop = 1; tick("drain"); end
    idle(); bus.ps_rts = 1; tick("rts_empty");
    chk("rts_empty.pm_add", bus.ps_pm_add, 16'h0);
    chk("rts_empty.stcky", bus.ps_stcky, 4'b1001);
    idle(); bus.ps_wrt_en = 1; bus.ps_wrt_add = 5'd30; bus.bc_dt = '0; tick("clr_unf");

    // call + rts together with top = 0x0042.
    idle(); bus.ps_psh = 1; tick("psh1");
    idle(); bus.ps_wrt_en = 1; bus.ps_wrt_add = 5'd4; bus.bc_dt = 16'h0042; tick("wtop");
    idle(); bus.ps_call = 1; bus.ps_rts = 1; bus.ps_jmp_add = 16'h0777; tick("call_rts");
    chk("call_rts.pm_add", bus.ps_pm_add, 16'h0042);
    chk("call_rts.stcky", bus.ps_stcky, 4'b0001);

    // Stall with a pending jump, then release.
    idle(); bus.ps_stall = 1; bus.ps_jmp = 1; bus.ps_jmp_add = 16'h0200;
    repeat (3) tick("stall");
    bus.ps_stall = 0; tick("unstall");
    chk("unstall.pm_add", bus.ps_pm_add, 16'h0200);
    idle(); bus.ps_wrt_en = 1; bus.ps_wrt_add = 5'd4; bus.ps_rd_add = 5'd4;
    bus.bc_dt = 16'hbeef; #1;
    chk("bypass", bus.ps_rd_dt, 16'hbeef);
    tick("bypass");

    // Randomized phase, with one asynchronous reset mid-run.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] adds [7];
      adds = '{5'd0, 5'd1, 5'd3, 5'd4, 5'd5, 5'd30, 5'd2};
      idle();
      bus.ps_stall   = ($urandom_range(0, 99) < 20);
      bus.ps_jmp     = ($urandom_range(0, 99) < 10);
      bus.ps_call    = ($urandom_range(0, 99) < 10);
      bus.ps_rts     = ($urandom_range(0, 99) < 10);
      bus.ps_psh     = ($urandom_range(0, 99) < 15);
      bus.ps_pop     = ($urandom_range(0, 99) < 10);
      bus.ps_jmp_add = 16'($urandom);
      bus.ps_wrt_en  = ($urandom_range(0, 99) < 30);
      bus.ps_wrt_add = ($urandom_range(0, 3) == 0) ? 5'($urandom) :
                       (($urandom_range(0, 1) == 0) ? 5'd4 : 5'd30);
      bus.ps_rd_add  = ($urandom_range(0, 7) == 0) ? 5'($urandom) :
                       adds[$urandom_range(0, 6)];
      bus.bc_dt      = 16'($urandom);
      if (i == 200) begin
        rst = 1'b0; #2;
        model_reset();
        chk("arst.pm_add", bus.ps_pm_add, 16'h0);
        chk("arst.pcvld", bus.ps_pcvld, 1'b0);
        chk("arst.stcky", bus.ps_stcky, 4'b0001);
        @(posedge clk); #1;
        rst = 1'b1;
      end
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
